// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RISC-V pipeline. Owns the program counter,
// drives the instruction-memory address straight from it, and captures the
// returned word into the IF/ID register, which is handed to decode over a
// valid/ready handshake.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   imem_addr      fetch address (always equal to the PC register)
//   imem_rdata     instruction word at imem_addr, valid in the same cycle
//   redirect_valid execute requests a PC change this cycle
//   redirect_pc    redirect target, sampled when redirect_valid is high
//   id_ready       decode accepts the current bundle this cycle
//   id_valid       IF/ID bundle is valid
//   id_instr       fetched instruction (NOP for a misaligned fetch)
//   id_pc          PC of id_instr
//   id_pc_plus4    id_pc + 4, wrapping modulo 2^32
//   id_misaligned  bundle PC had non-zero low bits
//
// Parameters
//   RESET_PC       PC value loaded on reset
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_misaligned
);

    // Canonical NOP (addi x0, x0, 0), substituted for misaligned fetches
    // and used as the reset value of the instruction register.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // RUN fetches normally; HALT parks the stage after a misaligned fetch
    // until execute redirects it somewhere sensible.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        pc_misaligned;
    logic        fire;

    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] bpc_next;
    logic [31:0] bpc_plus4_next;
    logic        misaligned_next;

    // The memory address is the PC itself; there is no fetch-ahead.
    assign imem_addr     = pc;
    assign pc_plus4      = pc + 32'd4;
    assign pc_misaligned = (pc[1:0] != 2'b00);

    // A new bundle is captured only while running, when the IF/ID slot is
    // empty or being drained this cycle, and when no redirect is pending.
    // A redirect always suppresses capture, which produces the one-cycle
    // bubble after every redirect.
    assign fire = (state == RUN) && (!id_valid || id_ready) && !redirect_valid;

    // Next-state and next-bundle logic. Redirect wins over everything else;
    // otherwise a fire loads the bundle, and a drain with no fire (only
    // possible in HALT) just clears the valid flag. All other cases hold,
    // which covers back-pressure: the bundle, PC and state stay put while
    // decode is stalled.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        valid_next      = id_valid;
        instr_next      = id_instr;
        bpc_next        = id_pc;
        bpc_plus4_next  = id_pc_plus4;
        misaligned_next = id_misaligned;

        if (redirect_valid) begin
            // Flush only the valid flag; the stale bundle fields are left
            // as they were since nobody looks at them while invalid.
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            state_next = RUN;
        end else if (fire) begin
            valid_next     = 1'b1;
            bpc_next       = pc;
            bpc_plus4_next = pc_plus4;
            if (pc_misaligned) begin
                // Hand decode a harmless NOP flagged as misaligned and stop
                // fetching; the PC stays at the offending address.
                instr_next      = NOP;
                misaligned_next = 1'b1;
                state_next      = HALT;
            end else begin
                instr_next      = imem_rdata;
                misaligned_next = 1'b0;
                pc_next         = pc_plus4;
            end
        end else if (id_valid && id_ready) begin
            valid_next = 1'b0;
        end
    end

    // State, PC and IF/ID register. Reset is asynchronous so a reset in the
    // middle of a stall or a halt drops everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            id_valid      <= 1'b0;
            id_instr      <= NOP;
            id_pc         <= 32'h0000_0000;
            id_pc_plus4   <= 32'h0000_0000;
            id_misaligned <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            id_valid      <= valid_next;
            id_instr      <= instr_next;
            id_pc         <= bpc_next;
            id_pc_plus4   <= bpc_plus4_next;
            id_misaligned <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small instruction memory table drives
// imem_rdata combinationally. Expected bundles are pushed onto a queue as the
// stimulus that should produce them is applied, and popped/compared whenever
// decode actually accepts a bundle (id_valid && id_ready before an edge).
// Direct checks cover reset values, stall holding, redirect bubbles, halt
// behaviour, PC wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
        logic        mis;
    } bundle_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_misaligned;

    bundle_t     expq[$];
    int          vectors     = 0;
    int          miscompares = 0;

    fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_misaligned  (id_misaligned)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents; unlisted addresses return a recognisable
    // filler word so a wrongly-captured word shows up in a compare.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: memWord = 32'h0000_2083;
            32'h0000_0004: memWord = 32'h0040_2103;
            32'h0000_0008: memWord = 32'h0040_0393;
            32'h0000_000C: memWord = 32'h0043_A023;
            32'h0000_0010: memWord = 32'h0010_8093;
            32'h0000_0014: memWord = 32'h0021_0113;
            32'h0000_0018: memWord = 32'h0083_A183;
            32'hFFFF_FFFC: memWord = 32'h0000_006F;
            default:       memWord = {16'hDEAD, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
    endtask

    task automatic pushBundle(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] plus4, input logic mis);
        bundle_t b;
        b.pc    = pc;
        b.instr = instr;
        b.plus4 = plus4;
        b.mis   = mis;
        expq.push_back(b);
    endtask

    // Consume a bundle if decode accepts one at the coming edge, then advance
    // one cycle and settle 1 unit past the edge.
    task automatic tick();
        bundle_t b;
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            checkOutput("sb_expected_bundle", {31'd0, expq.size() != 0}, 32'd1);
            if (expq.size() != 0) begin
                b = expq.pop_front();
                checkOutput("sb_pc",     id_pc,                  b.pc);
                checkOutput("sb_instr",  id_instr,               b.instr);
                checkOutput("sb_plus4",  id_pc_plus4,            b.plus4);
                checkOutput("sb_mis",    {31'd0, id_misaligned}, {31'd0, b.mis});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] fetch_stage bench start");
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        #2;

        // Reset values
        checkOutput("rst_valid", {31'd0, id_valid},      32'd0);
        checkOutput("rst_addr",  imem_addr,              32'h0);
        checkOutput("rst_instr", id_instr,               32'h0000_0013);
        checkOutput("rst_pc",    id_pc,                  32'h0);
        checkOutput("rst_plus4", id_pc_plus4,            32'h0);
        checkOutput("rst_mis",   {31'd0, id_misaligned}, 32'd0);

        // Reset and stream
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        pushBundle(32'h0, 32'h0000_2083, 32'h4, 1'b0);
        pushBundle(32'h4, 32'h0040_2103, 32'h8, 1'b0);
        pushBundle(32'h8, 32'h0040_0393, 32'hC, 1'b0);
        tick();
        checkOutput("first_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("first_pc",    id_pc,             32'h0);
        tick();
        checkOutput("second_pc",   id_pc,             32'h4);

        // Back-pressure with bundle 4 valid
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_valid", {31'd0, id_valid}, 32'd1);
            checkOutput("bp_pc",    id_pc,             32'h4);
            checkOutput("bp_instr", id_instr,          32'h0040_2103);
            checkOutput("bp_addr",  imem_addr,         32'h8);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("resume_pc", id_pc, 32'h8);
        tick();
        checkOutput("stream_c_pc", id_pc, 32'hC);

        // Redirect while bundle C is stalled; bundle C is flushed unaccepted
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("stall_c_pc", id_pc, 32'hC);
        applyStimulus(1'b1, 32'h18, 1'b0);
        tick();
        checkOutput("redir_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("redir_addr",  imem_addr,         32'h18);
        applyStimulus(1'b0, 32'h0, 1'b1);
        pushBundle(32'h18, 32'h0083_A183, 32'h1C, 1'b0);
        tick();
        checkOutput("redir_bundle_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("redir_bundle_pc",    id_pc,             32'h18);

        // Misaligned: redirect to 6 while bundle 0x18 is accepted
        applyStimulus(1'b1, 32'h6, 1'b1);
        tick();
        checkOutput("mis_bubble", {31'd0, id_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        pushBundle(32'h6, 32'h0000_0013, 32'hA, 1'b1);
        tick();
        checkOutput("mis_valid", {31'd0, id_valid},      32'd1);
        checkOutput("mis_flag",  {31'd0, id_misaligned}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("halt_valid", {31'd0, id_valid}, 32'd0);
            checkOutput("halt_addr",  imem_addr,         32'h6);
        end
        applyStimulus(1'b1, 32'h0, 1'b1);
        tick();
        checkOutput("restart_addr", imem_addr, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        pushBundle(32'h0, 32'h0000_2083, 32'h4, 1'b0);
        tick();
        checkOutput("restart_pc", id_pc, 32'h0);

        // Wrap: redirect to the top word while bundle 0 is accepted
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        pushBundle(32'hFFFF_FFFC, 32'h0000_006F, 32'h0, 1'b0);
        pushBundle(32'h0, 32'h0000_2083, 32'h4, 1'b0);
        pushBundle(32'h4, 32'h0040_2103, 32'h8, 1'b0);
        pushBundle(32'h8, 32'h0040_0393, 32'hC, 1'b0);
        tick();
        checkOutput("wrap_plus4", id_pc_plus4, 32'h0);
        checkOutput("wrap_addr",  imem_addr,   32'h0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("stream_addr_10", imem_addr, 32'h10);
        checkOutput("stream_pc_c",    id_pc,     32'hC);

        // Asynchronous reset mid-cycle; bundle C is discarded
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("arst_addr",  imem_addr,         32'h0);
        checkOutput("arst_instr", id_instr,          32'h0000_0013);
        checkOutput("arst_mis",   {31'd0, id_misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pushBundle(32'h0, 32'h0000_2083, 32'h4, 1'b0);
        tick();
        checkOutput("post_rst_valid", {31'd0, id_valid}, 32'd1);
        tick();

        checkOutput("sb_drained", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V pipeline. Holds the program counter and drives the instruction-memory address. It captures the returned word into an IF/ID pipeline register and presents it to decode through a valid/ready handshake. Supports back-pressure from decode, redirects from execute (branch/jump), and halts fetch on a misaligned PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address; equals PC register, combinational from it.
- imem_rdata  in  32  instruction word at imem_addr; combinational, valid in the same cycle.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  target PC; sampled when redirect_valid=1.
- id_ready  in  1  decode accepts the bundle this cycle.
- id_valid  out  1  IF/ID bundle is valid.
- id_instr  out  32  fetched instruction.
- id_pc  out  32  PC of id_instr.
- id_pc_plus4  out  32  id_pc + 4, mod 2^32.
- id_misaligned  out  1  bundle PC had pc[1:0] != 0; id_instr is NOP.

## Operation
- State machine has two states. RUN is the reset state. HALT is entered after a misaligned fetch.
- fire = state==RUN && (!id_valid || id_ready) && !redirect_valid.
- On fire with pc[1:0]==0:
  - id_valid<=1, id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_misaligned<=0.
  - pc<=pc+4, wrapping 0xFFFF_FFFC -> 0x0000_0000.
- On fire with pc[1:0]!=0:
  - id_valid<=1, id_instr<=32'h0000_0013, id_pc<=pc, id_pc_plus4<=pc+4, id_misaligned<=1.
  - pc holds; state<=HALT.
- When id_valid && !id_ready && !redirect_valid, everything holds: pc, bundle and state.
- When id_ready && id_valid and there is no fire (HALT), id_valid<=0.
- Redirect has the highest priority:
  - pc<=redirect_pc; id_valid<=0 (flush); state<=RUN.
  - This applies regardless of id_ready or state.
  - No bundle is produced in the redirect cycle.
  - If decode asserts id_ready in the same cycle, that transfer completes; killing it downstream is decode's job.
- HALT exits only via redirect or reset. In HALT, imem_addr still equals pc, but imem_rdata is ignored.
- Bundle fields other than id_valid are don't-care when id_valid=0 but hold their last value; they are not cleared on flush.

## Timing
- Reset, asynchronous, takes effect immediately:
  - pc=RESET_PC, imem_addr=RESET_PC, state=RUN.
  - id_valid=0, id_instr=32'h0000_0013, id_pc=0, id_pc_plus4=0, id_misaligned=0.
- First rising edge after rst deasserts: bundle for RESET_PC appears, so id_valid=1 one cycle after reset release.
- Latency is one cycle from imem_addr=X to id_pc=X and id_valid=1.
- With id_ready held at 1, throughput is one bundle per cycle.
- Redirect at edge N gives imem_addr=redirect_pc after N, and the target bundle valid after edge N+1. This is a one-cycle bubble.
- Asserting rst mid-stall or mid-HALT discards all state immediately. No bundle survives.

## Test plan
- Reset and stream. Memory holds 0x00002083 @0, 0x00402103 @4, 0x00400393 @8; id_ready=1.
  - Expect bundles (pc,instr) = (0,0x00002083), (4,0x00402103), (8,0x00400393) on consecutive cycles.
  - id_pc_plus4 = 4, 8, 0xC.
- Back-pressure. Drop id_ready for 3 cycles while the bundle at pc 4 is valid.
  - id_pc=4 and id_instr=0x00402103 are held stable; imem_addr stays 8.
  - Streaming resumes at pc 8 when id_ready returns.
- Redirect. Assert redirect_valid with redirect_pc=0x18 while a stalled bundle is valid.
  - Next cycle id_valid=0 and imem_addr=0x18.
  - Following cycle the bundle is (0x18, 0x0083a183).
- Misaligned. Redirect to 0x6.
  - Bundle id_pc=6, id_instr=0x00000013, id_misaligned=1.
  - After acceptance id_valid stays 0 and imem_addr stays 6.
  - A redirect to 0 restarts fetch at pc 0.
- Wrap. Redirect to 0xFFFF_FFFC.
  - Bundle id_pc=0xFFFF_FFFC, id_pc_plus4=0.
  - Next fetch is at pc 0.
- Async reset. Assert rst mid-cycle during streaming at pc 0x10.
  - Without waiting for an edge: id_valid=0, imem_addr=RESET_PC, id_instr=0x00000013.
